// File: rtl/count_frame_iw36_cw11.sv
// count_frame_iw36_cw11
// Receive side of the count-tagged sample interface. Incoming samples are
// registered, checked for count continuity, tagged with tlast, buffered in a
// small FIFO and replayed as AXI-Stream. The FIFO depth includes the output
// register, so the storage array never holds more than DEPTH-1 entries.

module count_frame_iw36_cw11 #(
  parameter int FIFO_AW = 4,
  parameter int FCNT_W  = 16
) (
  input  logic              clk,
  input  logic              sync_reset,
  input  logic [35:0]       data_i,
  input  logic [10:0]       count_i,
  input  logic              valid_i,
  input  logic [10:0]       high_cnt,
  output logic [35:0]       o_tdata,
  output logic              o_tlast,
  output logic              o_tvalid,
  input  logic              o_tready,
  output logic              seq_err,
  output logic              overflow,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int OCC_W = FIFO_AW + 1;

  logic [10:0]        lastCnt;
  logic               inLast;
  logic [10:0]        expCnt_q, expCnt_d;
  logic               seqErr_q, seqErr_d;
  logic               inValid_q;
  logic [35:0]        inData_q;
  logic               inLast_q;

  logic [36:0]        mem_q [DEPTH];
  logic [FIFO_AW-1:0] wrPtr_q, rdPtr_q;
  logic [OCC_W-1:0]   memCnt_q, memCnt_d;
  logic [OCC_W-1:0]   occ;

  logic               outValid_q;
  logic               outLast_q;
  logic [35:0]        outData_q;
  logic               overflow_q;
  logic [FCNT_W-1:0]  frameCnt_q;

  logic               pop, full, push, drop, memRead;

  // Block length 0 stands for 2048, which the 11-bit wrap gives for free.
  assign lastCnt = high_cnt - 11'd1;
  assign inLast  = (count_i == lastCnt);

  // Continuity check on every incoming sample, dropped or not; resync to what was seen.
  always_comb begin
    expCnt_d = expCnt_q;
    seqErr_d = 1'b0;
    if (valid_i) begin
      seqErr_d = (count_i != expCnt_q);
      expCnt_d = inLast ? 11'd0 : count_i + 11'd1;
    end
  end

  // FIFO bookkeeping: occupancy is storage plus the output register; a pop frees a full slot.
  always_comb begin
    pop      = outValid_q & o_tready;
    occ      = memCnt_q + OCC_W'(outValid_q);
    full     = (occ == OCC_W'(DEPTH));
    push     = inValid_q & (~full | pop);
    drop     = inValid_q & full & ~pop;
    memRead  = (memCnt_q != '0) & (~outValid_q | pop);
    memCnt_d = memCnt_q;
    if (push && !memRead) begin
      memCnt_d = memCnt_q + OCC_W'(1);
    end else if (!push && memRead) begin
      memCnt_d = memCnt_q - OCC_W'(1);
    end
  end

  // Input stage, pointers, output register, flags and frame counter.
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      expCnt_q   <= '0;
      seqErr_q   <= 1'b0;
      inValid_q  <= 1'b0;
      inData_q   <= '0;
      inLast_q   <= 1'b0;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      memCnt_q   <= '0;
      outValid_q <= 1'b0;
      outLast_q  <= 1'b0;
      outData_q  <= '0;
      overflow_q <= 1'b0;
      frameCnt_q <= '0;
    end else begin
      expCnt_q  <= expCnt_d;
      seqErr_q  <= seqErr_d;
      inValid_q <= valid_i;
      inData_q  <= data_i;
      inLast_q  <= inLast;
      memCnt_q  <= memCnt_d;
      if (push) begin
        wrPtr_q <= wrPtr_q + FIFO_AW'(1);
      end
      if (memRead) begin
        rdPtr_q    <= rdPtr_q + FIFO_AW'(1);
        outValid_q <= 1'b1;
        outData_q  <= mem_q[rdPtr_q][35:0];
        outLast_q  <= mem_q[rdPtr_q][36];
      end else if (pop) begin
        outValid_q <= 1'b0;
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
      if (pop && outLast_q) begin
        frameCnt_q <= frameCnt_q + FCNT_W'(1);
      end
    end
  end

  // Storage array holds {tlast, data}; stale contents are harmless after reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= {inLast_q, inData_q};
    end
  end

  assign o_tdata   = outData_q;
  assign o_tlast   = outLast_q;
  assign o_tvalid  = outValid_q;
  assign seq_err   = seqErr_q;
  assign overflow  = overflow_q;
  assign frame_cnt = frameCnt_q;

endmodule

// File: tb/tb_count_frame_iw36_cw11.sv
// Testbench for count_frame_iw36_cw11: directed scenarios plus a long random
// stall run, compared against a sample-level model of the stream.

module tb_count_frame_iw36_cw11;

  logic        clk = 1'b0;
  logic        sync_reset;
  logic [35:0] data_i;
  logic [10:0] count_i;
  logic        valid_i;
  logic [10:0] high_cnt;
  logic [35:0] o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        o_tready;
  logic        seq_err;
  logic        overflow;
  logic [15:0] frame_cnt;

  typedef struct packed {
    logic        last;
    logic [35:0] data;
  } entry_t;

  entry_t      expQ[$];
  int          total = 0;
  int          bad = 0;
  int          modelFrames = 0;
  int          expCount = 0;
  int          acceptBudget = -1;
  int          errPulses = 0;
  int          cyc = 0;
  int          firstIn = -1;
  int          firstOut = -1;
  int          pushed;
  logic        errDrv = 1'b0;
  logic        errExp = 1'b0;
  logic        prevStall = 1'b0;
  logic [35:0] prevData = '0;
  logic        prevLast = 1'b0;

  count_frame_iw36_cw11 dut (
    .clk       (clk),
    .sync_reset(sync_reset),
    .data_i    (data_i),
    .count_i   (count_i),
    .valid_i   (valid_i),
    .high_cnt  (high_cnt),
    .o_tdata   (o_tdata),
    .o_tlast   (o_tlast),
    .o_tvalid  (o_tvalid),
    .o_tready  (o_tready),
    .seq_err   (seq_err),
    .overflow  (overflow),
    .frame_cnt (frame_cnt)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Count edges and delay the expected seq_err by one edge, like a registered flag.
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    errExp <= errDrv;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Watch the output stream between edges: beats against the model, stalls, flags.
  always @(negedge clk) begin
    entry_t e;
    if (sync_reset) begin
      prevStall = 1'b0;
    end else begin
      checkOutput("seq_err", 64'(seq_err), 64'(errExp));
      if (seq_err) errPulses++;
      checkOutput("frame_cnt", 64'(frame_cnt), 64'(16'(modelFrames)));
      if (prevStall) begin
        checkOutput("stall_tvalid", 64'(o_tvalid), 64'd1);
        checkOutput("stall_tdata", 64'(o_tdata), 64'(prevData));
        checkOutput("stall_tlast", 64'(o_tlast), 64'(prevLast));
      end
      if (o_tvalid && firstOut < 0) firstOut = cyc;
      if (o_tvalid && o_tready) begin
        checkOutput("beat_expected", 64'(expQ.size() != 0), 64'd1);
        if (expQ.size() != 0) begin
          e = expQ.pop_front();
          checkOutput("beat_tdata", 64'(o_tdata), 64'(e.data));
          checkOutput("beat_tlast", 64'(o_tlast), 64'(e.last));
          if (e.last) modelFrames++;
        end
      end
      prevStall = o_tvalid && !o_tready;
      prevData  = o_tdata;
      prevLast  = o_tlast;
    end
  end

  // Drive one cycle of input and update the sample-level model.
  task automatic applyStimulus(input logic [35:0] d, input logic [10:0] c, input logic v);
    int   blockLen;
    logic isLast;
    valid_i = v;
    data_i  = d;
    count_i = c;
    errDrv  = 1'b0;
    if (v) begin
      blockLen = (high_cnt == 11'd0) ? 2048 : int'(high_cnt);
      isLast   = (int'(c) == blockLen - 1);
      errDrv   = (int'(c) != expCount);
      expCount = isLast ? 0 : int'(c) + 1;
      if (acceptBudget != 0) begin
        expQ.push_back({isLast, d});
        if (acceptBudget > 0) acceptBudget--;
      end
      if (firstIn < 0) firstIn = cyc + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(36'd0, 11'd0, 1'b0);
  endtask

  task automatic doReset();
    sync_reset = 1'b1;
    valid_i    = 1'b0;
    errDrv     = 1'b0;
    @(posedge clk);
    #1;
    sync_reset   = 1'b0;
    expQ.delete();
    modelFrames  = 0;
    expCount     = 0;
    acceptBudget = -1;
  endtask

  task automatic drain();
    o_tready = 1'b1;
    for (int i = 0; i < 400 && (expQ.size() != 0 || o_tvalid); i++) idle(1);
    idle(2);
    checkOutput("drain_queue_left", 64'(expQ.size()), 64'd0);
    checkOutput("drain_tvalid", 64'(o_tvalid), 64'd0);
  endtask

  function automatic logic [35:0] rnd36();
    return {4'($urandom), 32'($urandom)};
  endfunction

  // Bound the whole run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seq4[7];
    seq4 = '{0, 1, 2, 5, 6, 7, 0};
    sync_reset = 1'b1;
    valid_i    = 1'b0;
    data_i     = '0;
    count_i    = '0;
    high_cnt   = 11'd4;
    o_tready   = 1'b0;

    // Reset state
    doReset();
    @(negedge clk);
    checkOutput("rst_tvalid", 64'(o_tvalid), 64'd0);
    checkOutput("rst_tlast", 64'(o_tlast), 64'd0);
    checkOutput("rst_tdata", 64'(o_tdata), 64'd0);
    checkOutput("rst_seq_err", 64'(seq_err), 64'd0);
    checkOutput("rst_overflow", 64'(overflow), 64'd0);
    checkOutput("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    @(posedge clk);
    #1;

    // Scenario 1: three blocks of four, ready held high
    $display("[TB] scenario 1: basic framing");
    o_tready  = 1'b1;
    firstIn   = -1;
    firstOut  = -1;
    errPulses = 0;
    for (int i = 0; i < 12; i++) applyStimulus(rnd36(), 11'(i % 4), 1'b1);
    drain();
    checkOutput("s1_latency", 64'(firstOut - firstIn), 64'd2);
    checkOutput("s1_frame_cnt", 64'(frame_cnt), 64'd3);
    checkOutput("s1_seq_err_pulses", 64'(errPulses), 64'd0);

    // Scenario 2: stalled output, 20 pushes into 16 slots
    $display("[TB] scenario 2: overflow");
    o_tready     = 1'b0;
    acceptBudget = 16;
    for (int i = 0; i < 20; i++) applyStimulus(rnd36(), 11'(i % 4), 1'b1);
    idle(4);
    checkOutput("s2_overflow_set", 64'(overflow), 64'd1);
    drain();
    checkOutput("s2_overflow_sticky", 64'(overflow), 64'd1);
    checkOutput("s2_seq_err_pulses", 64'(errPulses), 64'd0);

    // Scenario 3: full FIFO, push and pop together
    $display("[TB] scenario 3: push while full and popping");
    doReset();
    high_cnt = 11'd4;
    o_tready = 1'b0;
    for (int i = 0; i < 16; i++) applyStimulus(rnd36(), 11'(i % 4), 1'b1);
    idle(3);
    checkOutput("s3_full_tvalid", 64'(o_tvalid), 64'd1);
    checkOutput("s3_full_no_overflow", 64'(overflow), 64'd0);
    o_tready = 1'b1;
    applyStimulus(rnd36(), 11'd0, 1'b1);
    drain();
    checkOutput("s3_overflow", 64'(overflow), 64'd0);

    // Scenario 4: count discontinuity
    $display("[TB] scenario 4: sequence error");
    doReset();
    high_cnt  = 11'd8;
    o_tready  = 1'b1;
    errPulses = 0;
    for (int i = 0; i < 7; i++) applyStimulus(rnd36(), 11'(seq4[i]), 1'b1);
    idle(2);
    checkOutput("s4_seq_err_pulses", 64'(errPulses), 64'd1);
    drain();
    checkOutput("s4_frame_cnt", 64'(frame_cnt), 64'd1);

    // Scenario 5: 2048-sample blocks with random ready and sparse input
    $display("[TB] scenario 5: random stalls");
    doReset();
    high_cnt  = 11'd0;
    errPulses = 0;
    pushed    = 0;
    for (int i = 0; i < 40000 && pushed < 4096; i++) begin
      o_tready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        applyStimulus(rnd36(), 11'(pushed % 2048), 1'b1);
        pushed++;
      end else begin
        idle(1);
      end
    end
    drain();
    checkOutput("s5_frame_cnt", 64'(frame_cnt), 64'd2);
    checkOutput("s5_overflow", 64'(overflow), 64'd0);
    checkOutput("s5_seq_err_pulses", 64'(errPulses), 64'd0);

    // Scenario 6: reset with samples buffered
    $display("[TB] scenario 6: reset mid-frame");
    doReset();
    high_cnt = 11'd8;
    o_tready = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(rnd36(), 11'(i), 1'b1);
    idle(3);
    checkOutput("s6_buffered_tvalid", 64'(o_tvalid), 64'd1);
    doReset();
    @(negedge clk);
    checkOutput("s6_tvalid", 64'(o_tvalid), 64'd0);
    checkOutput("s6_tdata", 64'(o_tdata), 64'd0);
    checkOutput("s6_tlast", 64'(o_tlast), 64'd0);
    checkOutput("s6_frame_cnt", 64'(frame_cnt), 64'd0);
    @(posedge clk);
    #1;
    errPulses = 0;
    applyStimulus(rnd36(), 11'd3, 1'b1);
    idle(2);
    checkOutput("s6_seq_err_pulses", 64'(errPulses), 64'd1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
